instruction_dispatcher: RTL and testbench
=========================================

// Module: instruction_dispatcher
// PURPOSE
//  Upstream command stage for memory_control. Accepts 32-bit instructions from the HPS PIO bridge,
//  decodes them, range-checks addresses and zoom limits, then issues one enable handshake per command.
//  Waits for completion, tracks the current zoom level and returns read data and status to the host.
//  Holds one pending instruction so the host can queue the next command while one executes.
// PARAMETERS
//  ADDR_W          17       framebuffer address width
//  DATA_W          8        pixel width
//  FB_PIXELS       76800    320x240; RD/WR address must be < FB_PIXELS
//  TIMEOUT_CYCLES  1048576  watchdog limit, in cycles, for each handshake phase
// PORTS
//  clock        in   1       system clock, rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  instr_in     in   32      [2:0] opcode, [19:3] addr, [27:20] color, [31:28] reserved (ignored)
//  instr_valid  in   1       host offers instr_in
//  instr_ready  out  1       pending slot empty; a transfer occurs when valid&&ready at a clock edge
//  mc_enable    out  1       single-cycle start pulse to memory_control
//  mc_operation out  3       opcode forwarded to memory_control
//  mc_addr_base out  ADDR_W  address forwarded
//  mc_color     out  DATA_W  write color forwarded
//  mc_zoom      out  3       current zoom forwarded
//  mc_done      in   1       memory_control done (high when idle)
//  mem_q        in   DATA_W  RAM read port data
//  rd_data      out  DATA_W  data captured by the last RD
//  zoom_level   out  3       001=0.25x 010=0.5x 011=1x 100=2x 101=4x
//  busy         out  1       command executing or pending
//  done_pulse   out  1       one cycle high when a command retires (success or error)
//  error_code   out  2       00 ok, 01 zoom limit, 10 timeout, 11 address range; valid until next retire
// BEHAVIOUR
//  Reset values:
//   - all mc_* = 0, rd_data = 0, zoom_level = 011, busy = 0, done_pulse = 0, error_code = 00
//   - instr_ready = 1, FSM = S_IDLE, pending slot empty
//  Opcodes:
//   - 000 NOP: retires with no memory operation
//   - 001 RD, 010 WR
//   - 011 NHI, 100 PR: zoom in
//   - 101 NH, 110 BA: zoom out
//   - 111 ZRESET: local only; zoom_level <= 011
//  Pending slot:
//   - Loads on a valid&&ready transfer; instr_ready = !slot_full.
//   - FSM pops the slot in S_IDLE. A push and a pop in the same cycle keep the slot full.
//  FSM:
//   - S_IDLE: if slot full, latch the instruction and clear the slot -> S_CHECK.
//   - S_CHECK (1 cycle):
//     - RD/WR with addr >= FB_PIXELS -> error 11, retire.
//     - zoom-in at 101 or zoom-out at 001 -> error 01, retire.
//     - NOP and ZRESET -> retire ok.
//     - otherwise -> S_ISSUE.
//   - S_ISSUE: only if mc_done==1. Drive mc_enable=1 for exactly 1 cycle -> S_WAIT_ACK.
//     mc_operation, mc_addr_base, mc_color and mc_zoom are held stable from S_ISSUE until retire.
//   - S_WAIT_ACK: wait for mc_done==0 -> S_WAIT_DONE.
//   - S_WAIT_DONE: wait for mc_done==1 -> S_RETIRE.
//   - S_RETIRE:
//     - RD: rd_data <= mem_q.
//     - zoom ops step zoom_level by +1 (in) or -1 (out).
//     - done_pulse = 1 -> S_IDLE.
//  Timeouts:
//   - Watchdog counter clears on entry to S_WAIT_ACK and S_WAIT_DONE.
//   - Reaching TIMEOUT_CYCLES -> error 10, retire. zoom_level and rd_data are unchanged.
//  Status:
//   - error_code updates only on retire.
//   - busy = (FSM != S_IDLE) || slot_full.
//  Latency: accepted instruction -> mc_enable in 3 cycles when the slot was empty and mc_done=1.
//  Reset asserted mid-operation aborts immediately to reset values; memory_control is not signalled.
// STRUCTURE
//  Package dispatcher_pkg holds:
//   - opcode localparams (matching memory_control encoding), zoom codes 001..101, error codes
//   - instruction field bit positions, FSM state encoding
//  Sub-module instr_slot: 1-entry valid/ready holding register with a same-cycle push/pop rule.
//  FSM, watchdog and zoom tracker stay in the top module.
// TESTING
//  1. WR addr=100 color=0xA5 -> mc_enable once, mc_addr_base=100, mc_color=A5; mc_done low 5 cycles
//     then high -> done_pulse, error 00.
//  2. RD addr=100 with mem_q=0x3C at retire -> rd_data=0x3C; RD addr=76800 -> error 11, no mc_enable.
//  3. From 1x issue PR, PR, PR -> zoom 100, then 101, then third is error 01 with no mc_enable.
//     Then ZRESET -> zoom 011.
//  4. Two back-to-back instructions -> second accepted while busy; instr_ready=0 when a third is offered.
//     Second mc_enable only after the first retires.
//  5. mc_done held high after enable -> error 10 after TIMEOUT_CYCLES; FSM idle, zoom unchanged.
//  6. reset_n pulled low during S_WAIT_DONE -> all outputs at reset values; slot empty; zoom 011.

Source files
------------

// File: rtl/dispatcher_pkg.sv
// Shared encodings for the instruction dispatcher: opcodes, zoom codes,
// error codes, instruction field positions and FSM states.
package dispatcher_pkg;

    // Opcodes, identical to the memory_control encoding
    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_RD     = 3'b001;
    localparam logic [2:0] OP_WR     = 3'b010;
    localparam logic [2:0] OP_NHI    = 3'b011;
    localparam logic [2:0] OP_PR     = 3'b100;
    localparam logic [2:0] OP_NH     = 3'b101;
    localparam logic [2:0] OP_BA     = 3'b110;
    localparam logic [2:0] OP_ZRESET = 3'b111;

    // Zoom levels, 0.25x up to 4x
    localparam logic [2:0] ZOOM_MIN  = 3'b001;
    localparam logic [2:0] ZOOM_1X   = 3'b011;
    localparam logic [2:0] ZOOM_MAX  = 3'b101;

    // Status codes reported on retire
    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ZOOM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ADDR    = 2'b11;

    // Instruction word layout: [2:0] opcode, [19:3] addr, [27:20] color
    localparam int INSTR_W   = 32;
    localparam int OP_LSB    = 0;
    localparam int ADDR_LSB  = 3;
    localparam int COLOR_LSB = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_RETIRE
    } state_t;

    function automatic logic is_zoom_in(input logic [2:0] op);
        return (op == OP_NHI) || (op == OP_PR);
    endfunction

    function automatic logic is_zoom_out(input logic [2:0] op);
        return (op == OP_NH) || (op == OP_BA);
    endfunction

    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_RD) || (op == OP_WR);
    endfunction

endpackage

// File: rtl/instr_slot.sv
// One-entry valid/ready holding register. A push and a pop in the same
// cycle leave the slot full, holding the newly pushed word.
module instr_slot #(
    parameter int W = 28
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push_valid_i,
    input  logic [W-1:0] push_data_i,
    output logic         push_ready_o,
    input  logic         pop_i,
    output logic         full_o,
    output logic [W-1:0] data_o
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;
    logic         push;

    assign push_ready_o = !full_q;
    assign push         = push_valid_i && !full_q;
    assign full_o       = full_q;
    assign data_o       = data_q;

    // Next-state: a push wins over a pop so the slot stays occupied
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (push) begin
            full_d = 1'b1;
            data_d = push_data_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    // Slot registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/instruction_dispatcher.sv
// Command front end for memory_control: buffers one host instruction,
// validates it, issues one enable handshake, waits for completion under a
// watchdog, tracks zoom and reports read data and status on retire.
module instruction_dispatcher
    import dispatcher_pkg::*;
#(
    parameter int ADDR_W         = 17,
    parameter int DATA_W         = 8,
    parameter int FB_PIXELS      = 76800,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              mc_enable,
    output logic [2:0]        mc_operation,
    output logic [ADDR_W-1:0] mc_addr_base,
    output logic [DATA_W-1:0] mc_color,
    output logic [2:0]        mc_zoom,
    input  logic              mc_done,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] rd_data,
    output logic [2:0]        zoom_level,
    output logic              busy,
    output logic              done_pulse,
    output logic [1:0]        error_code
);

    // Only the decoded fields are buffered; the reserved nibble is dropped
    localparam int          FIELD_W  = COLOR_LSB + DATA_W;
    localparam int          WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] FB_LIMIT = 32'(FB_PIXELS);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic               unused_reserved;
    logic               slot_full, slot_pop;
    logic [FIELD_W-1:0] slot_data;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   color_q, color_d;
    logic [1:0]          err_q, err_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic                mc_enable_q, mc_enable_d;
    logic [2:0]          mc_op_q, mc_op_d;
    logic [ADDR_W-1:0]   mc_addr_q, mc_addr_d;
    logic [DATA_W-1:0]   mc_color_q, mc_color_d;
    logic [2:0]          mc_zoom_q, mc_zoom_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [2:0]          zoom_q, zoom_d;
    logic [1:0]          error_code_q, error_code_d;
    logic                done_pulse_q, done_pulse_d;

    assign unused_reserved = ^instr_in[INSTR_W-1:FIELD_W];

    instr_slot #(.W(FIELD_W)) u_slot (
        .clock        (clock),
        .reset_n      (reset_n),
        .push_valid_i (instr_valid),
        .push_data_i  (instr_in[FIELD_W-1:0]),
        .push_ready_o (instr_ready),
        .pop_i        (slot_pop),
        .full_o       (slot_full),
        .data_o       (slot_data)
    );

    assign mc_enable    = mc_enable_q;
    assign mc_operation = mc_op_q;
    assign mc_addr_base = mc_addr_q;
    assign mc_color     = mc_color_q;
    assign mc_zoom      = mc_zoom_q;
    assign rd_data      = rd_data_q;
    assign zoom_level   = zoom_q;
    assign error_code   = error_code_q;
    assign done_pulse   = done_pulse_q;
    assign busy         = (state_q != S_IDLE) || slot_full;

    // FSM next-state plus all datapath updates
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        color_d      = color_q;
        err_d        = err_q;
        wdog_d       = wdog_q;
        mc_enable_d  = 1'b0;
        mc_op_d      = mc_op_q;
        mc_addr_d    = mc_addr_q;
        mc_color_d   = mc_color_q;
        mc_zoom_d    = mc_zoom_q;
        rd_data_d    = rd_data_q;
        zoom_d       = zoom_q;
        error_code_d = error_code_q;
        done_pulse_d = 1'b0;
        slot_pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (slot_full) begin
                    slot_pop = 1'b1;
                    op_d     = slot_data[OP_LSB +: 3];
                    addr_d   = slot_data[ADDR_LSB +: ADDR_W];
                    color_d  = slot_data[COLOR_LSB +: DATA_W];
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                err_d = ERR_OK;
                if (is_mem_op(op_q) && (32'(addr_q) >= FB_LIMIT)) begin
                    err_d   = ERR_ADDR;
                    state_d = S_RETIRE;
                end else if ((is_zoom_in(op_q) && zoom_q == ZOOM_MAX) ||
                             (is_zoom_out(op_q) && zoom_q == ZOOM_MIN)) begin
                    err_d   = ERR_ZOOM;
                    state_d = S_RETIRE;
                end else if (op_q == OP_NOP || op_q == OP_ZRESET) begin
                    state_d = S_RETIRE;
                end else begin
                    // Forwarded fields stay frozen until this command retires
                    mc_op_d    = op_q;
                    mc_addr_d  = addr_q;
                    mc_color_d = color_q;
                    mc_zoom_d  = zoom_q;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mc_done) begin
                    mc_enable_d = 1'b1;
                    wdog_d      = '0;
                    state_d     = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!mc_done) begin
                    wdog_d  = '0;
                    state_d = S_WAIT_DONE;
                end else if (wdog_q == WD_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_RETIRE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (mc_done) begin
                    state_d = S_RETIRE;
                end else if (wdog_q == WD_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_RETIRE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_RETIRE: begin
                done_pulse_d = 1'b1;
                error_code_d = err_q;
                if (err_q == ERR_OK) begin
                    if (op_q == OP_RD) begin
                        rd_data_d = mem_q;
                    end else if (is_zoom_in(op_q)) begin
                        zoom_d = zoom_q + 3'd1;
                    end else if (is_zoom_out(op_q)) begin
                        zoom_d = zoom_q - 3'd1;
                    end else if (op_q == OP_ZRESET) begin
                        zoom_d = ZOOM_1X;
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, watchdog and status registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q         <= OP_NOP;
            addr_q       <= '0;
            color_q      <= '0;
            err_q        <= ERR_OK;
            wdog_q       <= '0;
            mc_enable_q  <= 1'b0;
            mc_op_q      <= 3'b000;
            mc_addr_q    <= '0;
            mc_color_q   <= '0;
            mc_zoom_q    <= 3'b000;
            rd_data_q    <= '0;
            zoom_q       <= ZOOM_1X;
            error_code_q <= ERR_OK;
            done_pulse_q <= 1'b0;
        end else begin
            op_q         <= op_d;
            addr_q       <= addr_d;
            color_q      <= color_d;
            err_q        <= err_d;
            wdog_q       <= wdog_d;
            mc_enable_q  <= mc_enable_d;
            mc_op_q      <= mc_op_d;
            mc_addr_q    <= mc_addr_d;
            mc_color_q   <= mc_color_d;
            mc_zoom_q    <= mc_zoom_d;
            rd_data_q    <= rd_data_d;
            zoom_q       <= zoom_d;
            error_code_q <= error_code_d;
            done_pulse_q <= done_pulse_d;
        end
    end

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Directed bench for instruction_dispatcher: a table of single commands
// with hand-computed results, plus sequences for back-to-back queuing,
// watchdog timeout and reset during an operation.
module tb_instruction_dispatcher;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;
    localparam int FB     = 76800;
    localparam int TO     = 32;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [31:0]       instr_in = '0;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic              mc_enable;
    logic [2:0]        mc_operation;
    logic [ADDR_W-1:0] mc_addr_base;
    logic [DATA_W-1:0] mc_color;
    logic [2:0]        mc_zoom;
    logic              mc_done;
    logic [DATA_W-1:0] mem_q = '0;
    logic [DATA_W-1:0] rd_data;
    logic [2:0]        zoom_level;
    logic              busy;
    logic              done_pulse;
    logic [1:0]        error_code;

    always #5 clock = ~clock;

    instruction_dispatcher #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_PIXELS(FB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset_n(reset_n), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .mc_enable(mc_enable), .mc_operation(mc_operation),
        .mc_addr_base(mc_addr_base), .mc_color(mc_color), .mc_zoom(mc_zoom),
        .mc_done(mc_done), .mem_q(mem_q), .rd_data(rd_data), .zoom_level(zoom_level),
        .busy(busy), .done_pulse(done_pulse), .error_code(error_code)
    );

    // memory_control stand-in: drops done for mc_lat cycles per enable unless hung
    logic mc_hang = 1'b0;
    int   mc_lat  = 5;
    int   mc_cnt;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mc_done <= 1'b1;
            mc_cnt  <= 0;
        end else if (mc_enable && !mc_hang) begin
            mc_done <= 1'b0;
            mc_cnt  <= mc_lat;
        end else if (mc_cnt > 0) begin
            mc_cnt <= mc_cnt - 1;
            if (mc_cnt == 1) mc_done <= 1'b1;
        end
    end

    // Enable counter and snapshot of the forwarded fields at each enable
    int                en_count = 0;
    logic [2:0]        cap_op, cap_zoom;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_color;
    always @(posedge clock) begin
        if (mc_enable) begin
            en_count  <= en_count + 1;
            cap_op    <= mc_operation;
            cap_addr  <= mc_addr_base;
            cap_color <= mc_color;
            cap_zoom  <= mc_zoom;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] op, input logic [16:0] addr,
                                       input logic [7:0] color, input logic [3:0] rsv);
        return {rsv, color, addr, op};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, " mc_enable"},    32'(mc_enable), 0);
        check({tag, " mc_operation"}, 32'(mc_operation), 0);
        check({tag, " mc_addr_base"}, 32'(mc_addr_base), 0);
        check({tag, " mc_color"},     32'(mc_color), 0);
        check({tag, " mc_zoom"},      32'(mc_zoom), 0);
        check({tag, " rd_data"},      32'(rd_data), 0);
        check({tag, " zoom_level"},   32'(zoom_level), 3);
        check({tag, " busy"},         32'(busy), 0);
        check({tag, " done_pulse"},   32'(done_pulse), 0);
        check({tag, " error_code"},   32'(error_code), 0);
        check({tag, " instr_ready"},  32'(instr_ready), 1);
    endtask

    // Send one instruction into an empty slot, wait for its retire, check results
    task automatic run_cmd(input logic [31:0] instr, input logic [1:0] exp_err, input int exp_en,
                           input logic [2:0] exp_zoom, input logic [7:0] exp_rd,
                           input string tag, output int cycles);
        int base, lat;
        logic [2:0] z0;
        logic got;
        base = en_count; z0 = zoom_level; lat = -1; got = 1'b0; cycles = -1;
        @(negedge clock);
        check({tag, " ready"}, 32'(instr_ready), 1);
        instr_in = instr; instr_valid = 1'b1;
        @(posedge clock);
        #1 instr_valid = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clock); #1;
            if (mc_enable && lat < 0) lat = k;
            if (done_pulse) begin got = 1'b1; cycles = k; break; end
        end
        check({tag, " retired"}, 32'(got), 1);
        check({tag, " error_code"}, 32'(error_code), 32'(exp_err));
        check({tag, " zoom_level"}, 32'(zoom_level), 32'(exp_zoom));
        check({tag, " rd_data"}, 32'(rd_data), 32'(exp_rd));
        check({tag, " enables"}, 32'(en_count - base), 32'(exp_en));
        check({tag, " busy after"}, 32'(busy), 0);
        if (exp_en > 0) begin
            check({tag, " latency"}, 32'(lat), 3);
            check({tag, " mc_operation"}, 32'(cap_op), 32'(instr[2:0]));
            check({tag, " mc_addr_base"}, 32'(cap_addr), 32'(instr[19:3]));
            check({tag, " mc_color"}, 32'(cap_color), 32'(instr[27:20]));
            check({tag, " mc_zoom"}, 32'(cap_zoom), 32'(z0));
        end
        $display("txn %s instr=%08h err=%0d zoom=%0d rd=%02h en=%0d cyc=%0d",
                 tag, instr, error_code, zoom_level, rd_data, en_count - base, cycles);
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [7:0]  mem;
        logic [1:0]  err;
        int          en;
        logic [2:0]  zoom;
        logic [7:0]  rd;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int cyc, base, acc, ndone;

        // Reset state
        repeat (3) @(posedge clock);
        #1 check_reset_values("reset");
        @(negedge clock) reset_n = 1'b1;

        vecs[0]  = '{"wr100",    mk(3'b010, 17'd100,   8'hA5, 4'h0), 8'hEE, 2'b00, 1, 3'd3, 8'h00};
        vecs[1]  = '{"rd100",    mk(3'b001, 17'd100,   8'h00, 4'hF), 8'h3C, 2'b00, 1, 3'd3, 8'h3C};
        vecs[2]  = '{"rd76800",  mk(3'b001, 17'd76800, 8'h00, 4'h0), 8'h77, 2'b11, 0, 3'd3, 8'h3C};
        vecs[3]  = '{"wr76800",  mk(3'b010, 17'd76800, 8'h12, 4'h0), 8'hEE, 2'b11, 0, 3'd3, 8'h3C};
        vecs[4]  = '{"wr76799",  mk(3'b010, 17'd76799, 8'h5A, 4'h0), 8'hEE, 2'b00, 1, 3'd3, 8'h3C};
        vecs[5]  = '{"pr1",      mk(3'b100, 17'd0,     8'h00, 4'h0), 8'hEE, 2'b00, 1, 3'd4, 8'h3C};
        vecs[6]  = '{"pr2",      mk(3'b100, 17'd0,     8'h00, 4'h0), 8'hEE, 2'b00, 1, 3'd5, 8'h3C};
        vecs[7]  = '{"pr3",      mk(3'b100, 17'd0,     8'h00, 4'h0), 8'hEE, 2'b01, 0, 3'd5, 8'h3C};
        vecs[8]  = '{"nhi_max",  mk(3'b011, 17'd0,     8'h00, 4'h0), 8'hEE, 2'b01, 0, 3'd5, 8'h3C};
        vecs[9]  = '{"zreset1",  mk(3'b111, 17'd0,     8'h00, 4'h0), 8'hEE, 2'b00, 0, 3'd3, 8'h3C};
        vecs[10] = '{"nh",       mk(3'b101, 17'd0,     8'h00, 4'h0), 8'hEE, 2'b00, 1, 3'd2, 8'h3C};
        vecs[11] = '{"ba1",      mk(3'b110, 17'd0,     8'h00, 4'h0), 8'hEE, 2'b00, 1, 3'd1, 8'h3C};
        vecs[12] = '{"ba_min",   mk(3'b110, 17'd0,     8'h00, 4'h0), 8'hEE, 2'b01, 0, 3'd1, 8'h3C};
        vecs[13] = '{"nop",      mk(3'b000, 17'd5,     8'h00, 4'h0), 8'hEE, 2'b00, 0, 3'd1, 8'h3C};
        vecs[14] = '{"zreset2",  mk(3'b111, 17'd0,     8'h00, 4'h0), 8'hEE, 2'b00, 0, 3'd3, 8'h3C};
        vecs[15] = '{"rd76799",  mk(3'b001, 17'd76799, 8'h00, 4'h0), 8'h81, 2'b00, 1, 3'd3, 8'h81};

        foreach (vecs[i]) begin
            mem_q = vecs[i].mem;
            run_cmd(vecs[i].instr, vecs[i].err, vecs[i].en, vecs[i].zoom, vecs[i].rd, vecs[i].name, cyc);
        end

        // Back-to-back: second queues while the first runs, third is refused
        base = en_count; acc = 0;
        @(negedge clock);
        instr_in = mk(3'b010, 17'd10, 8'h11, 4'h0); instr_valid = 1'b1;
        @(posedge clock); #1;
        check("b2b busy", 32'(busy), 1);
        instr_in = mk(3'b010, 17'd20, 8'h22, 4'h0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (instr_ready) begin @(posedge clock); #1; acc = 1; break; end
        end
        check("b2b second accepted", 32'(acc), 1);
        instr_in = mk(3'b010, 17'd30, 8'h33, 4'h0);
        acc = 0;
        repeat (3) begin
            @(negedge clock);
            if (instr_ready) acc++;
        end
        instr_valid = 1'b0;
        check("b2b third refused", 32'(acc), 0);
        ndone = 0;
        for (int k = 0; k < 200 && ndone < 2; k++) begin
            @(posedge clock); #1;
            if (done_pulse) begin
                ndone++;
                check($sformatf("b2b enables at retire %0d", ndone), 32'(en_count - base), 32'(ndone));
                check($sformatf("b2b addr at retire %0d", ndone), 32'(cap_addr), 32'(ndone * 10));
                check($sformatf("b2b error at retire %0d", ndone), 32'(error_code), 0);
            end
        end
        check("b2b two retires", 32'(ndone), 2);
        $display("txn b2b retires=%0d enables=%0d last_addr=%0d", ndone, en_count - base, cap_addr);

        // Zoom in once, then time out a zoom-out with done stuck high
        mem_q = 8'hEE;
        run_cmd(mk(3'b100, 17'd0, 8'h00, 4'h0), 2'b00, 1, 3'd4, 8'h81, "pr_pre", cyc);
        mc_hang = 1'b1;
        run_cmd(mk(3'b101, 17'd0, 8'h00, 4'h0), 2'b10, 1, 3'd4, 8'h81, "timeout", cyc);
        check("timeout window", 32'((cyc >= TO) && (cyc <= TO + 8)), 1);
        mc_hang = 1'b0;

        // Reset while waiting for done
        mc_lat = 30; acc = 0;
        @(negedge clock);
        instr_in = mk(3'b010, 17'd7, 8'h44, 4'h0); instr_valid = 1'b1;
        @(posedge clock); #1 instr_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            if (!mc_done) begin acc = 1; break; end
        end
        check("midreset mc busy", 32'(acc), 1);
        repeat (2) @(posedge clock);
        #1;
        check("midreset busy before", 32'(busy), 1);
        #2 reset_n = 1'b0;
        #1 check_reset_values("midreset");
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        mc_lat = 5;
        run_cmd(mk(3'b010, 17'd9, 8'h66, 4'h0), 2'b00, 1, 3'd3, 8'h00, "post_reset", cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
